// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Purpose  : Stall / flush / forwarding controller for a 5-stage RV32I
//             pipeline. Shadows the EX, MEM and WB stage metadata and derives
//             operand forwarding selects, ID-stage WB bypass, load-use (or
//             full RAW) interlocks, redirect flushes and a global freeze while
//             the data memory is busy. Also counts stall cycles, accepted
//             redirects and retired instructions.
//  Ports    :
//    i_clk, i_reset             clock, synchronous active-high reset
//    i_id_*                     ID-stage instruction metadata
//    i_ex_redirect              branch taken / jump resolved in EX
//    i_mem_busy                 data memory not ready (freeze everything)
//    o_pc_write, o_ifid_write   front-end update enables
//    o_ifid_flush, o_idex_flush NOP injection into IF/ID and ID/EX
//    o_ex_fwd_a/b               00 regfile, 01 EX/MEM result, 10 WB data
//    o_id_bypass_a/b            ID operand read replaced by WB write data
//    o_stall_cycles, o_flush_count, o_retired   wrapping event counters
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_ENABLE = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_is_load,
    input  logic                  i_ex_redirect,
    input  logic                  i_mem_busy,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_ifid_flush,
    output logic                  o_idex_flush,
    output logic [1:0]            o_ex_fwd_a,
    output logic [1:0]            o_ex_fwd_b,
    output logic                  o_id_bypass_a,
    output logic                  o_id_bypass_b,
    output logic [CNT_WIDTH-1:0]  o_stall_cycles,
    output logic [CNT_WIDTH-1:0]  o_flush_count,
    output logic [CNT_WIDTH-1:0]  o_retired
);

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_MEM = 2'b01;
    localparam logic [1:0] c_FWD_WB  = 2'b10;

    // ------------------------------------------------------------------
    // Stage metadata shadow. EX also keeps its source operands so the
    // forwarding selects can be formed for the instruction executing now.
    // WB needs no load flag: WB data is always final.
    // ------------------------------------------------------------------
    logic                  r_ex_valid, r_ex_rw, r_ex_load, r_ex_use1, r_ex_use2;
    logic [REG_ADDR_W-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
    logic                  r_mem_valid, r_mem_rw, r_mem_load;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_valid, r_wb_rw;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    logic [CNT_WIDTH-1:0]  r_stall_cycles, r_flush_count, r_retired;

    // A producer slot only counts when it really writes a non-x0 register
    // that the consumer actually reads.
    function automatic logic f_match(
        input logic                  valid,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  uses
    );
        return valid & reg_write & (rd != '0) & (rd == rs) & uses;
    endfunction

    logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;

    assign w_ex_m1  = f_match(r_ex_valid,  r_ex_rw,  r_ex_rd,  i_id_rs1, i_id_uses_rs1);
    assign w_ex_m2  = f_match(r_ex_valid,  r_ex_rw,  r_ex_rd,  i_id_rs2, i_id_uses_rs2);
    assign w_mem_m1 = f_match(r_mem_valid, r_mem_rw, r_mem_rd, i_id_rs1, i_id_uses_rs1);
    assign w_mem_m2 = f_match(r_mem_valid, r_mem_rw, r_mem_rd, i_id_rs2, i_id_uses_rs2);
    assign w_wb_m1  = f_match(r_wb_valid,  r_wb_rw,  r_wb_rd,  i_id_rs1, i_id_uses_rs1);
    assign w_wb_m2  = f_match(r_wb_valid,  r_wb_rw,  r_wb_rd,  i_id_rs2, i_id_uses_rs2);

    logic       w_interlock;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_bypass_a, w_bypass_b;

    generate
        if (FWD_ENABLE != 0) begin : g_fwd
            logic w_fm_a, w_fm_b, w_fw_a, w_fw_b;

            // Only a load in EX cannot be forwarded in time.
            assign w_interlock = r_ex_load & (w_ex_m1 | w_ex_m2);

            // Matches against the instruction currently in EX.
            assign w_fm_a = r_ex_valid & f_match(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_rs1, r_ex_use1);
            assign w_fm_b = r_ex_valid & f_match(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_rs2, r_ex_use2);
            assign w_fw_a = r_ex_valid & f_match(r_wb_valid,  r_wb_rw,  r_wb_rd,  r_ex_rs1, r_ex_use1);
            assign w_fw_b = r_ex_valid & f_match(r_wb_valid,  r_wb_rw,  r_wb_rd,  r_ex_rs2, r_ex_use2);

            // MEM is the younger producer and wins; a MEM load never has
            // its data on the ALU result path, so it is excluded.
            assign w_fwd_a = (w_fm_a & ~r_mem_load) ? c_FWD_MEM :
                             w_fw_a                 ? c_FWD_WB  : c_FWD_RF;
            assign w_fwd_b = (w_fm_b & ~r_mem_load) ? c_FWD_MEM :
                             w_fw_b                 ? c_FWD_WB  : c_FWD_RF;

            // Regfile write and ID read share a cycle; hand WB data to ID.
            assign w_bypass_a = w_wb_m1;
            assign w_bypass_b = w_wb_m2;
        end else begin : g_nofwd
            logic w_unused_nofwd;

            // Without forwarding the consumer waits until the producer has
            // left WB and the register file holds the value.
            assign w_interlock = w_ex_m1 | w_ex_m2 | w_mem_m1 | w_mem_m2 | w_wb_m1 | w_wb_m2;
            assign w_fwd_a     = c_FWD_RF;
            assign w_fwd_b     = c_FWD_RF;
            assign w_bypass_a  = 1'b0;
            assign w_bypass_b  = 1'b0;
            assign w_unused_nofwd = &{1'b0, r_ex_rs1, r_ex_rs2, r_ex_use1, r_ex_use2, r_mem_load};
        end
    endgenerate

    logic w_freeze, w_redirect, w_stall;

    assign w_freeze   = i_mem_busy;
    assign w_redirect = i_ex_redirect & ~i_mem_busy;
    // A redirect squashes the ID instruction anyway, so no stall for it.
    assign w_stall    = w_interlock & i_id_valid & ~i_ex_redirect;

    // Priority: freeze > redirect > stall > normal flow.
    always_comb begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        if (w_freeze) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (w_redirect) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_stall) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_rw        <= 1'b0;
            r_ex_load      <= 1'b0;
            r_ex_use1      <= 1'b0;
            r_ex_use2      <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_rw       <= 1'b0;
            r_mem_load     <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_rw        <= 1'b0;
            r_wb_rd        <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
            r_retired      <= '0;
        end else begin
            if (w_stall || w_freeze) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (!w_freeze) begin
                r_wb_valid  <= r_mem_valid;
                r_wb_rw     <= r_mem_rw;
                r_wb_rd     <= r_mem_rd;
                r_mem_valid <= r_ex_valid;
                r_mem_rw    <= r_ex_rw;
                r_mem_load  <= r_ex_load;
                r_mem_rd    <= r_ex_rd;
                if (w_redirect || w_stall) begin
                    // Bubble: cleared completely so it can never match.
                    r_ex_valid <= 1'b0;
                    r_ex_rw    <= 1'b0;
                    r_ex_load  <= 1'b0;
                    r_ex_use1  <= 1'b0;
                    r_ex_use2  <= 1'b0;
                    r_ex_rd    <= '0;
                    r_ex_rs1   <= '0;
                    r_ex_rs2   <= '0;
                end else begin
                    r_ex_valid <= i_id_valid;
                    r_ex_rw    <= i_id_reg_write;
                    r_ex_load  <= i_id_is_load;
                    r_ex_use1  <= i_id_uses_rs1;
                    r_ex_use2  <= i_id_uses_rs2;
                    r_ex_rd    <= i_id_rd;
                    r_ex_rs1   <= i_id_rs1;
                    r_ex_rs2   <= i_id_rs2;
                end
                if (r_wb_valid) begin
                    r_retired <= r_retired + CNT_WIDTH'(1);
                end
                if (w_redirect) begin
                    r_flush_count <= r_flush_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign o_ex_fwd_a     = w_fwd_a;
    assign o_ex_fwd_b     = w_fwd_b;
    assign o_id_bypass_a  = w_bypass_a;
    assign o_id_bypass_b  = w_bypass_b;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
    assign o_retired      = r_retired;

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central stall/flush/forwarding controller for the 5-stage RV32I pipeline.
- Replaces the externally driven fwd/pc_write controls of the datapath.
- Keeps an internal metadata shadow (valid, rd, reg_write, is_load) of the EX, MEM and WB stages.
- Generates forwarding selects, load-use/RAW interlocks, branch/jump flushes and a global freeze for a slow dmem, and counts stall, flush and retire events.

Parameters:
REG_ADDR_W, 5, register index width; index 0 never creates a hazard.
FWD_ENABLE, 1, 1 = forwarding with load-use interlock only; 0 = no forwarding, full RAW interlock.
CNT_WIDTH, 32, width of the performance counters (wrap modulo 2^CNT_WIDTH).

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous active-high reset
i_id_valid  in  1  the ID stage holds a real instruction
i_id_rs1  in  REG_ADDR_W  ID source register 1
i_id_rs2  in  REG_ADDR_W  ID source register 2
i_id_uses_rs1  in  1  ID instruction reads rs1
i_id_uses_rs2  in  1  ID instruction reads rs2
i_id_rd  in  REG_ADDR_W  ID destination register
i_id_reg_write  in  1  ID instruction writes rd
i_id_is_load  in  1  ID instruction is a load
i_ex_redirect  in  1  EX branch taken or jump (PC redirect)
i_mem_busy  in  1  dmem not ready; freeze the whole pipeline
o_pc_write  out  1  PC update enable
o_ifid_write  out  1  IF/ID register update enable
o_ifid_flush  out  1  load NOP into IF/ID
o_idex_flush  out  1  load NOP (bubble) into ID/EX
o_ex_fwd_a  out  2  00 regfile, 01 EX/MEM alu_result, 10 WB write data
o_ex_fwd_b  out  2  same encoding as o_ex_fwd_a
o_id_bypass_a  out  1  ID rs1 read replaced by WB write data
o_id_bypass_b  out  1  ID rs2 read replaced by WB write data
o_stall_cycles  out  CNT_WIDTH  cycles with an interlock or freeze active
o_flush_count  out  CNT_WIDTH  redirects accepted
o_retired  out  CNT_WIDTH  valid instructions leaving WB

Behaviour:
- Reset:
  - All stage slots invalid; all counters 0.
  - o_pc_write = 1, o_ifid_write = 1, all flush, forward and bypass outputs 0.
  - Reset mid-operation discards all slots on the same edge.
- Outputs are combinational from the slots and ID inputs. Slots and counters update on i_clk.
- Hazard match: a slot is valid, has reg_write, rd != 0, rd equals the ID source, and the matching uses_rsX is 1.
- Load-use, FWD_ENABLE = 1: the EX slot is a load and matches rs1 or rs2.
- RAW interlock, FWD_ENABLE = 0: any of the EX, MEM or WB slots matches.
- stall = interlock & i_id_valid & ~i_ex_redirect.
  - o_pc_write = 0, o_ifid_write = 0, o_idex_flush = 1.
  - Slot advance inserts an invalid EX slot.
- redirect = i_ex_redirect & ~i_mem_busy.
  - o_ifid_flush = 1, o_idex_flush = 1, o_pc_write = 1.
  - The EX slot is filled invalid; o_flush_count increments.
  - Redirect beats stall in the same cycle.
- freeze = i_mem_busy. Highest priority.
  - o_pc_write = 0, o_ifid_write = 0, all flushes 0.
  - No slot moves and no counter increments except o_stall_cycles.
  - A redirect held during freeze is accepted on the first non-busy cycle.
- Normal advance:
  - WB ← MEM, MEM ← EX.
  - EX ← ID inputs (valid = i_id_valid), or invalid on stall/redirect.
  - o_retired increments when the old WB slot is valid.
- Forwarding, FWD_ENABLE = 1 (per operand; fwd fields are taken from the EX slot's rs1/rs2, which are latched with the slot):
  - MEM slot match, not a load → 01.
  - Else WB slot match → 10.
  - Else 00.
  - MEM has priority over WB. A MEM load match cannot occur because the interlock prevents it.
- o_id_bypass_x = 1 when FWD_ENABLE = 1 and the WB slot matches the ID source; ID captures WB data.
- FWD_ENABLE = 0: all forward and bypass outputs are constant 0.
- o_stall_cycles increments on any cycle with stall or freeze.
- All counters wrap.

Test Plan:
- Reset then 3 independent ALU ops → fwd 00, no stalls, o_retired = 3 after 7 cycles, o_stall_cycles = 0.
- FWD = 1, `add x5` in EX then `sub x6, x5, x1` in ID → next cycle o_ex_fwd_a = 01; one cycle later a consumer of x5 gets 10; x0 producer → 00.
- FWD = 1, `lw x5` in EX, `add x7, x5, x5` in ID → exactly 1 cycle: pc_write = 0, ifid_write = 0, idex_flush = 1; then fwd_a = fwd_b = 10; o_stall_cycles = 1.
- FWD = 0, `add x5` then a dependent op → 3 stall cycles, then o_id_bypass 0 and fwd 00; o_stall_cycles = 3.
- i_ex_redirect concurrent with a load-use match → ifid_flush = 1, idex_flush = 1, pc_write = 1, o_flush_count = 1, no stall counted.
- i_mem_busy high 4 cycles with redirect pending → outputs frozen, o_stall_cycles += 4, flush fires on cycle 5; i_reset asserted mid-freeze → all counters 0 next cycle.
